// File: rtl/way_write_steer_if.sv
// Interface bundle for way_write_steer.
// Purpose : carries the write request, the read-hit touch strobe and the
//           steered way write port between the cache controller (master)
//           and the write steering unit (slave).
// Signals : req_valid/req_ready handshake with index/tag/data/hit/hit_way,
//           touch_valid/touch_index/touch_way LRU strobe,
//           way0_we/way1_we plus shared wr_index/wr_tag/wr_data,
//           done pulse and held done_way.
interface way_write_steer_if #(
   parameter int INDEX_W = 3,
   parameter int TAG_W   = 3,
   parameter int DATA_W  = 8
);
   logic               req_valid;
   logic               req_ready;
   logic [INDEX_W-1:0] req_index;
   logic [TAG_W-1:0]   req_tag;
   logic [DATA_W-1:0]  req_data;
   logic               req_hit;
   logic               req_hit_way;

   logic               touch_valid;
   logic [INDEX_W-1:0] touch_index;
   logic               touch_way;

   logic               way0_we;
   logic               way1_we;
   logic [INDEX_W-1:0] wr_index;
   logic [TAG_W-1:0]   wr_tag;
   logic [DATA_W-1:0]  wr_data;
   logic               done;
   logic               done_way;

   modport master (
      output req_valid,
      output req_index,
      output req_tag,
      output req_data,
      output req_hit,
      output req_hit_way,
      output touch_valid,
      output touch_index,
      output touch_way,
      input  req_ready,
      input  way0_we,
      input  way1_we,
      input  wr_index,
      input  wr_tag,
      input  wr_data,
      input  done,
      input  done_way
   );

   modport slave (
      input  req_valid,
      input  req_index,
      input  req_tag,
      input  req_data,
      input  req_hit,
      input  req_hit_way,
      input  touch_valid,
      input  touch_index,
      input  touch_way,
      output req_ready,
      output way0_we,
      output way1_we,
      output wr_index,
      output wr_tag,
      output wr_data,
      output done,
      output done_way
   );
endinterface

// File: rtl/way_write_steer.sv
// Write-side way steering for a 2-way set-associative cache.
// Purpose : accepts one write (hit update or miss fill), picks the target
//           way from hit info, per-set valid bits and a per-set LRU bit,
//           pulses exactly one way write enable and keeps LRU current.
// Ports   : clk, rst (async, active high)
//           bus (slave) : request handshake, touch strobe, way write
//                         enables, registered index/tag/data, done/done_way.
module way_write_steer #(
   parameter int INDEX_W = 3,
   parameter int TAG_W   = 3,
   parameter int DATA_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   way_write_steer_if.slave bus
);

   localparam int SETS = 1 << INDEX_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SELECT = 2'd1,
      WRITE  = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [INDEX_W-1:0] idx_q;
   logic [TAG_W-1:0]   tag_q;
   logic [DATA_W-1:0]  data_q;
   logic               hit_q;
   logic               hit_way_q;
   logic               tgt_q;
   logic               done_way_q;

   logic [SETS-1:0]    valid0_q;
   logic [SETS-1:0]    valid1_q;
   logic [SETS-1:0]    lru_q;

   logic               sel_way;
   logic               accept;
   logic               ready_c;
   logic               we0_c;
   logic               we1_c;
   logic               done_c;

   assign accept = (state_q == IDLE) && bus.req_valid;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and decoded outputs
   always_comb begin
      state_d = state_q;
      ready_c = 1'b0;
      we0_c   = 1'b0;
      we1_c   = 1'b0;
      done_c  = 1'b0;
      unique case (state_q)
         IDLE: begin
            ready_c = 1'b1;
            if (bus.req_valid) begin
               state_d = SELECT;
            end
         end
         SELECT: begin
            state_d = WRITE;
         end
         WRITE: begin
            we0_c   = ~tgt_q;
            we1_c   = tgt_q;
            state_d = DONE;
         end
         DONE: begin
            done_c  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Request capture; these registers also drive the shared way write bus
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q     <= '0;
         tag_q     <= '0;
         data_q    <= '0;
         hit_q     <= 1'b0;
         hit_way_q <= 1'b0;
      end else if (accept) begin
         idx_q     <= bus.req_index;
         tag_q     <= bus.req_tag;
         data_q    <= bus.req_data;
         hit_q     <= bus.req_hit;
         hit_way_q <= bus.req_hit_way;
      end
   end

   // Target way: hit way, then first invalid way, then the LRU way
   always_comb begin
      sel_way = lru_q[idx_q];
      if (hit_q) begin
         sel_way = hit_way_q;
      end else if (!valid0_q[idx_q]) begin
         sel_way = 1'b0;
      end else if (!valid1_q[idx_q]) begin
         sel_way = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tgt_q <= 1'b0;
      end else if (state_q == SELECT) begin
         tgt_q <= sel_way;
      end
   end

   // done_way is loaded at the end of WRITE so it is already valid
   // while done is high, then held until the next completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_way_q <= 1'b0;
      end else if (state_q == WRITE) begin
         done_way_q <= tgt_q;
      end
   end

   // Valid bits are only ever set by a write; hits re-set an already
   // valid line, so nothing is evicted by a hit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid0_q <= '0;
         valid1_q <= '0;
      end else if (state_q == WRITE) begin
         if (tgt_q) begin
            valid1_q[idx_q] <= 1'b1;
         end else begin
            valid0_q[idx_q] <= 1'b1;
         end
      end
   end

   // Touch is applied first so that a write to the same set in the same
   // cycle overrides it; different sets both update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lru_q <= '0;
      end else begin
         if (bus.touch_valid) begin
            lru_q[bus.touch_index] <= ~bus.touch_way;
         end
         if (state_q == WRITE) begin
            lru_q[idx_q] <= ~tgt_q;
         end
      end
   end

   assign bus.req_ready = ready_c;
   assign bus.way0_we   = we0_c;
   assign bus.way1_we   = we1_c;
   assign bus.done      = done_c;
   assign bus.done_way  = done_way_q;
   assign bus.wr_index  = idx_q;
   assign bus.wr_tag    = tag_q;
   assign bus.wr_data   = data_q;

endmodule

// File: tb/tb_way_write_steer.sv
// Self-checking bench for way_write_steer.
// Directed scenarios plus a random stream checked by a small model.
module tb_way_write_steer;

   localparam int IW   = 3;
   localparam int TW   = 3;
   localparam int DW   = 8;
   localparam int SETS = 8;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   way_write_steer_if #(
      .INDEX_W(IW),
      .TAG_W  (TW),
      .DATA_W (DW)
   ) bus ();

   way_write_steer #(
      .INDEX_W(IW),
      .TAG_W  (TW),
      .DATA_W (DW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   typedef struct {
      logic          way;
      logic [IW-1:0] idx;
      logic [TW-1:0] tag;
      logic [DW-1:0] data;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   int checks = 0;
   int errors = 0;

   logic m_v0  [SETS];
   logic m_v1  [SETS];
   logic m_lru [SETS];

   // Scoreboard: every way write must match the oldest pushed request
   always @(negedge clk) begin
      if (!rst && (bus.way0_we || bus.way1_we)) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_write we1=%b we0=%b",
                     bus.way1_we, bus.way0_we);
         end else begin
            mon_e = sb_q.pop_front();
            if ({bus.way1_we, bus.way0_we, bus.wr_index,
                 bus.wr_tag, bus.wr_data} !==
                {mon_e.way, ~mon_e.way, mon_e.idx,
                 mon_e.tag, mon_e.data}) begin
               errors++;
               $display("FAIL sb_write got we=%b%b idx=%0d tag=%0d data=%h exp way=%0d idx=%0d tag=%0d data=%h",
                        bus.way1_we, bus.way0_we, bus.wr_index,
                        bus.wr_tag, bus.wr_data, mon_e.way,
                        mon_e.idx, mon_e.tag, mon_e.data);
            end
         end
      end
   end

   task automatic do_req(
      input logic [IW-1:0] idx,
      input logic [TW-1:0] tag,
      input logic [DW-1:0] data,
      input logic          hit,
      input logic          hw,
      input logic          exp_way,
      input logic          tch,
      input logic [IW-1:0] tidx,
      input logic          tway
   );
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!bus.req_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_wait got=%b exp=1", bus.req_ready);
      end
      e.way  = exp_way;
      e.idx  = idx;
      e.tag  = tag;
      e.data = data;
      sb_q.push_back(e);
      bus.req_valid   = 1'b1;
      bus.req_index   = idx;
      bus.req_tag     = tag;
      bus.req_data    = data;
      bus.req_hit     = hit;
      bus.req_hit_way = hw;
      @(posedge clk);
      #1;
      // Scramble inputs: they must be ignored after the accept edge
      bus.req_valid   = 1'b0;
      bus.req_index   = ~idx;
      bus.req_tag     = ~tag;
      bus.req_data    = ~data;
      bus.req_hit     = ~hit;
      bus.req_hit_way = ~hw;
      @(negedge clk);
      checks++;
      if ({bus.req_ready, bus.way0_we, bus.way1_we, bus.done}
          !== 4'b0000) begin
         errors++;
         $display("FAIL select_phase got rdy/we0/we1/done=%b%b%b%b exp=0000",
                  bus.req_ready, bus.way0_we, bus.way1_we, bus.done);
      end
      @(negedge clk);
      checks++;
      if ({bus.way1_we, bus.way0_we} !==
          (exp_way ? 2'b10 : 2'b01)) begin
         errors++;
         $display("FAIL write_we idx=%0d got we1we0=%b%b exp_way=%0d",
                  idx, bus.way1_we, bus.way0_we, exp_way);
      end
      if (tch) begin
         bus.touch_valid = 1'b1;
         bus.touch_index = tidx;
         bus.touch_way   = tway;
      end
      @(posedge clk);
      #1;
      bus.touch_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b1 || bus.done_way !== exp_way ||
          bus.way0_we !== 1'b0 || bus.way1_we !== 1'b0) begin
         errors++;
         $display("FAIL done idx=%0d got done=%b done_way=%b exp done=1 done_way=%b",
                  idx, bus.done, bus.done_way, exp_way);
      end
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b1 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL ready_back got rdy=%b done=%b exp rdy=1 done=0",
                  bus.req_ready, bus.done);
      end
   endtask

   task automatic miss(input logic [IW-1:0] idx,
                       input logic [TW-1:0] tag,
                       input logic          exp_way);
      do_req(idx, tag, {5'h15, tag}, 1'b0, 1'b0, exp_way,
             1'b0, '0, 1'b0);
   endtask

   task automatic touch(input logic [IW-1:0] idx, input logic way);
      @(negedge clk);
      bus.touch_valid = 1'b1;
      bus.touch_index = idx;
      bus.touch_way   = way;
      @(posedge clk);
      #1;
      bus.touch_valid = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.req_ready, bus.way0_we, bus.way1_we, bus.done,
           bus.done_way} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_ctrl got rdy/we0/we1/done/dway=%b%b%b%b%b exp=10000",
                  bus.req_ready, bus.way0_we, bus.way1_we,
                  bus.done, bus.done_way);
      end
      checks++;
      if ({bus.wr_index, bus.wr_tag, bus.wr_data} !== '0) begin
         errors++;
         $display("FAIL reset_bus got idx=%0d tag=%0d data=%h exp=0",
                  bus.wr_index, bus.wr_tag, bus.wr_data);
      end
      rst = 1'b0;
   endtask

   task automatic test_fill();
      miss(3'd2, 3'd5, 1'b0);
      miss(3'd2, 3'd6, 1'b1);
      miss(3'd2, 3'd7, 1'b0);
   endtask

   task automatic test_hit();
      do_req(3'd2, 3'd6, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
      // lru[2] is now 0 and both ways still valid
      miss(3'd2, 3'd1, 1'b0);
   endtask

   task automatic test_touch_lru();
      miss(3'd4, 3'd1, 1'b0);
      miss(3'd4, 3'd2, 1'b1);
      touch(3'd4, 1'b0);
      miss(3'd4, 3'd3, 1'b1);
   endtask

   task automatic test_touch_during_write();
      miss(3'd3, 3'd1, 1'b0);
      miss(3'd3, 3'd2, 1'b1);
      // Same-set touch would make lru=1; the write must leave lru=0
      do_req(3'd3, 3'd2, 8'h77, 1'b1, 1'b1, 1'b1,
             1'b1, 3'd3, 1'b0);
      miss(3'd3, 3'd4, 1'b0);
      miss(3'd5, 3'd1, 1'b0);
      miss(3'd5, 3'd2, 1'b1);
      // Different-set touch during a write still applies
      do_req(3'd3, 3'd4, 8'h99, 1'b1, 1'b0, 1'b0,
             1'b1, 3'd5, 1'b0);
      miss(3'd5, 3'd3, 1'b1);
   endtask

   task automatic test_reset_mid_write();
      exp_t e;
      miss(3'd6, 3'd1, 1'b0);
      miss(3'd6, 3'd2, 1'b1);
      e.way  = 1'b0;
      e.idx  = 3'd6;
      e.tag  = 3'd3;
      e.data = 8'hE3;
      @(negedge clk);
      sb_q.push_back(e);
      bus.req_valid = 1'b1;
      bus.req_index = 3'd6;
      bus.req_tag   = 3'd3;
      bus.req_data  = 8'hE3;
      bus.req_hit   = 1'b0;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.way0_we !== 1'b1) begin
         errors++;
         $display("FAIL midwr_we0 got=%b exp=1", bus.way0_we);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.req_ready, bus.way0_we, bus.way1_we, bus.done,
           bus.done_way, bus.wr_index} !== {5'b10000, 3'd0}) begin
         errors++;
         $display("FAIL midwr_reset got rdy/we0/we1/done/dway=%b%b%b%b%b idx=%0d exp=10000 idx=0",
                  bus.req_ready, bus.way0_we, bus.way1_we,
                  bus.done, bus.done_way, bus.wr_index);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (bus.done !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midwr_nodone cyc=%0d got done=%b rdy=%b exp done=0 rdy=1",
                     i, bus.done, bus.req_ready);
         end
      end
      miss(3'd5, 3'd6, 1'b0);
      miss(3'd6, 3'd7, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [IW-1:0] idx;
      logic          hit;
      logic          hw;
      logic          w;
      pulse_reset();
      for (int s = 0; s < SETS; s++) begin
         m_v0[s]  = 1'b0;
         m_v1[s]  = 1'b0;
         m_lru[s] = 1'b0;
      end
      for (int i = 0; i < 30; i++) begin
         idx = IW'($urandom_range(0, SETS - 1));
         hit = ($urandom_range(0, 3) == 0);
         hw  = 1'($urandom_range(0, 1));
         if (hit) w = hw;
         else if (!m_v0[idx]) w = 1'b0;
         else if (!m_v1[idx]) w = 1'b1;
         else w = m_lru[idx];
         do_req(idx, TW'($urandom), DW'($urandom), hit, hw, w,
                1'b0, '0, 1'b0);
         if (w) m_v1[idx] = 1'b1;
         else m_v0[idx] = 1'b1;
         m_lru[idx] = ~w;
      end
   endtask

   initial begin
      rst             = 1'b1;
      bus.req_valid   = 1'b0;
      bus.req_index   = '0;
      bus.req_tag     = '0;
      bus.req_data    = '0;
      bus.req_hit     = 1'b0;
      bus.req_hit_way = 1'b0;
      bus.touch_valid = 1'b0;
      bus.touch_index = '0;
      bus.touch_way   = 1'b0;
      test_reset();
      test_fill();
      test_hit();
      test_touch_lru();
      test_touch_during_write();
      test_reset_mid_write();
      test_back_to_back();
      repeat (2) @(negedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover got=%0d exp=0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/way_write_steer.md
# way_write_steer

Write-side steering unit for the 2-way set-associative cache: where the read path selects one of two way outputs, this block routes one write (hit update or miss fill) into one of the two ways. It picks the target way from the hit information, per-set valid bits and a per-set LRU bit. It drives exactly one way write enable per request and keeps the replacement state current. It sits between the cache controller, which issues write requests, and the two way tag/data arrays.

## Interface
Parameters:
- INDEX_W, 3, set index width; SETS = 2**INDEX_W
- TAG_W, 3, tag width
- DATA_W, 8, data word width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  write request present
- req_ready  output  1  block can accept a request (high only in IDLE)
- req_index  input  INDEX_W  target set
- req_tag  input  TAG_W  tag to write
- req_data  input  DATA_W  data to write
- req_hit  input  1  request hits an existing line
- req_hit_way  input  1  way that hit (ignored if req_hit=0)
- touch_valid  input  1  read-hit LRU update strobe
- touch_index  input  INDEX_W  set of read hit
- touch_way  input  1  way of read hit
- way0_we  output  1  write enable, way 0
- way1_we  output  1  write enable, way 1
- wr_index  output  INDEX_W  registered set index to both ways
- wr_tag  output  TAG_W  registered tag to both ways
- wr_data  output  DATA_W  registered data to both ways
- done  output  1  one-cycle completion pulse
- done_way  output  1  way written; held until next completion

## Operation
- State: valid[2][SETS], lru[SETS]. lru[s]=0 means way 0 is least recently used; lru[s]=1 means way 1.
- FSM states: IDLE, SELECT, WRITE, DONE.
  - IDLE: req_ready=1. On req_valid, capture index/tag/data/hit/hit_way and go to SELECT.
  - SELECT: compute target way, in priority order:
    1. hit_way if hit;
    2. else way 0 if valid[0][idx]=0;
    3. else way 1 if valid[1][idx]=0;
    4. else lru[idx].
    Register the target and go to WRITE.
  - WRITE: assert the target's wayN_we for exactly one cycle; set valid[target][idx]=1 and lru[idx]=~target; go to DONE.
  - DONE: pulse done=1, set done_way=target; go to IDLE.
- Touch: in any state, touch_valid sets lru[touch_index]=~touch_way at the clock edge.
- Touch during WRITE to the same index: the WRITE update wins. Different index: both updates apply.
- Hits never evict: valid bits are only set, never cleared, except by reset.
- wr_index/wr_tag/wr_data update at capture and hold until the next capture.

## Timing
- Accept at edge T (IDLE, req_valid=1). SELECT in cycle T+1, wayN_we high in cycle T+2, done high in cycle T+3. req_ready is high again in cycle T+4, so throughput is one request per 4 cycles.
- Request inputs are sampled only at the accept edge; changes afterward are ignored.
- way0_we and way1_we are never high together, and never high outside WRITE.
- Reset (asynchronous, any state including mid-WRITE) drives:
  - state to IDLE, req_ready=1;
  - way0_we=way1_we=0, done=0, done_way=0;
  - wr_index, wr_tag, wr_data to 0;
  - all valid and all lru bits to 0.
- An in-flight request is discarded without completion. The first edge after rst deasserts may accept a request.

## Test plan
- After reset, fill set 2 with tag 5 (miss) -> way0_we high in cycle T+2, wr_index=2, wr_tag=5; done_way=0 in T+3; lru[2]=1.
- Second miss to set 2 with tag 6 -> way1_we; done_way=1. Third miss with tag 7 -> evicts way 0 (lru[2]=0 after the second fill); done_way=0.
- Hit write to set 2 with req_hit=1, req_hit_way=1 -> way1_we only; lru[2] becomes 0; valid unchanged.
- Both ways of set 4 valid, lru[4]=0; touch_valid with touch_way=0 on set 4 -> a following miss fill evicts way 1.
- Touch set 3 with touch_way=0 in the same cycle as WRITE to set 3 into way 1 -> lru[3]=0 (write result); touch to set 5 in the same cycle -> lru[5] also updated.
- Assert rst in cycle T+2 during a WRITE -> way enables drop immediately, no done pulse, req_ready=1, and the next miss to any set targets way 0.
